i8088_bus_responder: RTL
========================

I8088_BUS_RESPONDER -- requirements
Module: i8088_bus_responder

Interface
Parameters:
REQ-001 BASE_ADDR, 20'h00000, base of the decoded window; bits [19:ADDR_BITS] are compared.
REQ-002 ADDR_BITS, 8, offset width; the internal byte storage SHALL be 2**ADDR_BITS deep (legal 4..12).
REQ-003 IS_IO, 0, the block responds only when the latched IOM equals IS_IO.
REQ-004 WAIT_STATES, 2, number of READY-low clocks inserted per selected cycle (legal 0..7).

Ports:
REQ-005 CLK input 1: the single clock; all state SHALL update on the rising edge.
REQ-006 RESET input 1: synchronous, active-high reset.
REQ-007 ALE input 1: address latch enable from the processor.
REQ-008 IOM input 1: IO/memory select, sampled with ALE.
REQ-009 A input 12 [19:8]: upper address.
REQ-010 AD inout 8: multiplexed address/data; the block drives it only in state DRIVE and holds it high-Z otherwise.
REQ-011 RD input 1: active-low read strobe.
REQ-012 WR input 1: active-low write strobe.
REQ-013 READY output 1: wait-state request, 1 = ready.
REQ-014 ERR output 1: one-clock pulse on a protocol error.

Function
REQ-015 The block SHALL implement the states IDLE, ADDR, WAIT, DRIVE, WRITE and DONE.
REQ-016 On any edge where ALE=1, the block SHALL latch addr={A,AD} and IOM and enter ADDR; this takes priority over every other transition, so an ALE in mid-cycle aborts that cycle and relatches.
REQ-017 The cycle SHALL be selected when the latched IOM equals IS_IO and addr[19:ADDR_BITS] equals BASE_ADDR[19:ADDR_BITS].
REQ-018 From ADDR, when the cycle is unselected the block SHALL return to IDLE and drive nothing.
REQ-019 From ADDR, when the cycle is selected:
- RD=0 and WR=1: go to WAIT if WAIT_STATES>0, else go to DRIVE.
- WR=0 and RD=1: go to WAIT if WAIT_STATES>0, else go to WRITE.
- Both strobes high: remain in ADDR.
REQ-020 Entering WAIT SHALL load a counter with WAIT_STATES and drive READY=0; the counter SHALL decrement each clock, and at 1 the block SHALL set READY=1 and go to DRIVE or WRITE according to the strobe.
REQ-021 READY SHALL be low for exactly WAIT_STATES consecutive clocks per selected cycle and high at all other times.
REQ-022 DRIVE: AD SHALL carry mem[addr[ADDR_BITS-1:0]] from the edge entering DRIVE until the edge on which RD is sampled high, at which the block SHALL release AD and go to IDLE.
REQ-023 WRITE: on the entering edge, the block SHALL write mem[offset] with AD as sampled at that edge, then go to DONE; DONE SHALL return to IDLE when WR is sampled high.
REQ-024 Each WR-low period SHALL produce exactly one write.
REQ-025 RD=0 and WR=0 sampled together in ADDR, WAIT, DRIVE or WRITE SHALL cause:
- no write and no drive;
- ERR=1 for one clock;
- READY=1;
- return to IDLE.
REQ-026 The offset SHALL wrap modulo 2**ADDR_BITS; no access outside the window SHALL touch the storage.
REQ-027 Strobes seen in IDLE without a preceding ALE SHALL be ignored.

Reset
REQ-028 While RESET=1 the block SHALL force: state=IDLE, READY=1, ERR=0, AD high-Z, wait counter=0, latched address=0.
REQ-029 Reset asserted mid-cycle SHALL take effect on the next edge; any write not yet performed SHALL be dropped.
REQ-030 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-031 With I8088_RESP_WAIT_EN defined, the WAIT state and counter SHALL exist and WAIT_STATES SHALL apply.
REQ-032 Without I8088_RESP_WAIT_EN, WAIT SHALL not exist, READY SHALL be constant 1, ADDR SHALL go directly to DRIVE or WRITE, and WAIT_STATES SHALL be ignored.

Verification
REQ-033 Memory read, defaults, mem[8'h34]=8'hA5: ALE with IOM=0, A=12'h000, AD=8'h34, then RD low -> READY low exactly 2 clocks, then AD=8'hA5 until RD high, then AD high-Z.
REQ-034 Write then read: cycle to 20'h00012 with WR low and AD=8'h5C, then a read of 20'h00012 -> read returns 8'h5C; exactly one write occurs.
REQ-035 Unselected cycles:
- address 20'h00112, or IOM=1 with IS_IO=0 -> READY stays 1, AD never driven, storage unchanged.
REQ-036 RD and WR low together after ALE to 20'h00001 -> ERR pulses 1 clock, READY=1, no drive, mem[1] unchanged.
REQ-037 RESET during the second WAIT clock of a write -> next edge: READY=1, state IDLE, write dropped; a subsequent read returns the old value.
REQ-038 Build without I8088_RESP_WAIT_EN, read of 20'h00034 -> READY never low; AD is driven starting the edge after RD is sampled low.

Source files
------------

// File: rtl/i8088_bus_responder.sv
// Byte-wide slave on the 8088 multiplexed bus: decodes one memory or IO window and serves reads/writes.
// Optional wait-state generation is compiled in by defining I8088_RESP_WAIT_EN.
module i8088_bus_responder #(
    parameter logic [19:0] BASE_ADDR   = 20'h00000,
    parameter int          ADDR_BITS   = 8,
    parameter bit          IS_IO       = 1'b0,
    parameter int          WAIT_STATES = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ALE,
    input  logic        IOM,
    input  logic [19:8] A,
    inout  wire  [7:0]  AD,
    input  logic        RD,
    input  logic        WR,
    output logic        READY,
    output logic        ERR
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WAIT,
        DRIVE,
        WRITE,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [19:0]          addr_q, addr_d;
    logic                 iom_q, iom_d;
    logic                 err_q, err_d;
    logic                 mem_we;
    logic [7:0]           mem [DEPTH];
    logic [ADDR_BITS-1:0] offset;
    logic                 selected;
    logic                 rd_req, wr_req, both_low;

`ifdef I8088_RESP_WAIT_EN
    logic [2:0] cnt_q, cnt_d;
    logic       ready_q, ready_d;
`else
    logic       unused_wait_states;
    assign unused_wait_states = (WAIT_STATES != 0);
`endif

    assign offset   = addr_q[ADDR_BITS-1:0];
    assign selected = (iom_q == IS_IO) && (addr_q[19:ADDR_BITS] == BASE_ADDR[19:ADDR_BITS]);
    assign rd_req   = !RD && WR;
    assign wr_req   = RD && !WR;
    assign both_low = !RD && !WR;

    // ALE outranks everything, then the conflicting-strobe check, then the normal cycle walk.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        iom_d   = iom_q;
        err_d   = 1'b0;
`ifdef I8088_RESP_WAIT_EN
        cnt_d   = cnt_q;
`endif
        if (ALE) begin
            state_d = ADDR;
            addr_d  = {A, AD};
            iom_d   = IOM;
        end else if (both_low && (state_q inside {ADDR, WAIT, DRIVE, WRITE})) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                ADDR: begin
                    if (!selected) begin
                        state_d = IDLE;
                    end else if (rd_req || wr_req) begin
                        state_d = rd_req ? DRIVE : WRITE;
`ifdef I8088_RESP_WAIT_EN
                        if (WAIT_STATES != 0) begin
                            state_d = WAIT;
                            cnt_d   = 3'(WAIT_STATES);
                        end
`endif
                    end
                end
`ifdef I8088_RESP_WAIT_EN
                WAIT: begin
                    if (cnt_q <= 3'd1) begin
                        cnt_d   = 3'd0;
                        state_d = rd_req ? DRIVE : (wr_req ? WRITE : IDLE);
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
`endif
                DRIVE: if (RD) state_d = IDLE;
                WRITE: state_d = DONE;
                DONE:  if (WR) state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
        // The only way into WRITE is the storing edge, so one store per WR-low period.
        mem_we = (state_d == WRITE) && (state_q != WRITE) && !RESET;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            addr_q  <= 20'h00000;
            iom_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            iom_q   <= iom_d;
            err_q   <= err_d;
        end
    end

`ifdef I8088_RESP_WAIT_EN
    assign ready_d = (state_d != WAIT);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q   <= 3'd0;
            ready_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    assign READY = ready_q;
`else
    assign READY = 1'b1;
`endif

    // Storage is deliberately left out of reset.
    always_ff @(posedge CLK) begin
        if (mem_we) mem[offset] <= AD;
    end

    assign AD  = (state_q == DRIVE) ? mem[offset] : 8'hzz;
    assign ERR = err_q;

endmodule
